// File: rtl/uart_transmitter_if.sv
// Byte-input handshake for the UART transmitter.
// The producer drives data_in/data_in_valid. A byte moves on a rising edge where valid and ready are both high.
interface uart_transmitter_if;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;

  modport master (
    output data_in,
    output data_in_valid,
    input  data_in_ready
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_in_ready
  );
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small input FIFO.
// Each frame is one start bit, eight data bits (LSB first) and one stop bit. Each bit lasts CLOCK_FREQ/BAUD_RATE cycles.
module uart_transmitter #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  uart_transmitter_if.slave   in_if,
  output logic                serial_out,
  output logic                tx_busy,
  output logic [1:0]          state_dbg
);
  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME) + 1;
  localparam int PTR_W            = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   OCC_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   OCC_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  // Transmit FSM registers and their next values
  state_t           state,    state_n;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_cnt,  bit_cnt_n;
  logic [7:0]       shift,    shift_n;
  logic             ser_n;
  logic             bit_done;

  assign fifo_empty          = (occ == '0);
  assign in_if.data_in_ready = (occ != OCC_FULL);
  assign push                = in_if.data_in_valid && in_if.data_in_ready;
  assign tx_busy             = (state != IDLE) || !fifo_empty;
  assign state_dbg           = state;
  assign bit_done            = (baud_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= in_if.data_in;
    end
  end

  // Occupancy counter tells full from empty; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      serial_out <= 1'b1;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_cnt_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      serial_out <= ser_n;
    end
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    ser_n      = serial_out;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_n    = mem[rd_ptr];
          ser_n      = 1'b0;
          bit_cnt_n  = '0;
          baud_cnt_n = '0;
          state_n    = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_cnt_n = '0;
          ser_n      = shift[0];
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + CNT_ONE;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_cnt_n = '0;
          if (bit_cnt == 3'd7) begin
            ser_n   = 1'b1;
            state_n = STOP;
          end else begin
            // shift[1] is the bit that becomes shift[0] after this edge
            shift_n   = {1'b0, shift[7:1]};
            ser_n     = shift[1];
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end else begin
          baud_cnt_n = baud_cnt + CNT_ONE;
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_cnt_n = '0;
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_n   = mem[rd_ptr];
            ser_n     = 1'b0;
            bit_cnt_n = '0;
            state_n   = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: instance A uses the default clock and baud rate (434 cycles per bit), and instance B runs at 10 cycles per bit.
// A line monitor compares each frame against the bytes that the bench queued.
module tb_uart_transmitter;
  localparam int BT_A = 50_000_000 / 115_200;
  localparam int BT_B = 1000 / 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ser_a, ser_b, busy_a, busy_b;
  logic [1:0] st_a, st_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int epoch = 0;
  int frames_ok0 = 0;
  int frames_ok1 = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int st_q0[$];
  int st_q1[$];

  uart_transmitter_if ifa ();
  uart_transmitter_if ifb ();

  uart_transmitter dut_a (
    .clk(clk), .rst(rst), .in_if(ifa),
    .serial_out(ser_a), .tx_busy(busy_a), .state_dbg(st_a)
  );

  uart_transmitter #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .in_if(ifb),
    .serial_out(ser_b), .tx_busy(busy_b), .state_dbg(st_b)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic ser_of(input int id);
    return (id == 0) ? ser_a : ser_b;
  endfunction

  function automatic logic rdy_of(input int id);
    return (id == 0) ? ifa.data_in_ready : ifb.data_in_ready;
  endfunction

  function automatic logic busy_of(input int id);
    return (id == 0) ? busy_a : busy_b;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // driver tasks
  task automatic drive(input int id, input logic v, input logic [7:0] d);
    if (id == 0) begin
      ifa.data_in_valid = v;
      ifa.data_in       = d;
    end else begin
      ifb.data_in_valid = v;
      ifb.data_in       = d;
    end
  endtask

  // Called at a negedge: holds valid until ready is seen, then queues the byte as expected output.
  task automatic send(input int id, input logic [7:0] b, output int acc_edge);
    int guard;
    guard = 0;
    drive(id, 1'b1, b);
    while (!rdy_of(id) && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (!rdy_of(id)) begin
      check("send_timeout", 0, 1);
      acc_edge = -1;
    end else begin
      acc_edge = cyc + 1;
      if (id == 0) exp_q0.push_back(b);
      else exp_q1.push_back(b);
    end
    @(negedge clk);
  endtask

  task automatic idle_in(input int id);
    drive(id, 1'b0, 8'($urandom));
  endtask

  task automatic wait_idle(input int id, input int limit, output int fall_cyc);
    int g;
    g = 0;
    while (busy_of(id) && g < limit) begin
      @(negedge clk);
      g++;
    end
    check("wait_idle", int'(busy_of(id)), 0);
    fall_cyc = cyc;
  endtask

  // Line monitor: detects a start bit, pops the expected byte and checks every cycle of the 10-bit frame.
  task automatic monitor(input int id);
    int bt, ep, mis;
    logic [9:0] fr;
    logic [7:0] e, dec;
    logic have, aborted;
    bt = (id == 0) ? BT_A : BT_B;
    forever begin
      @(negedge clk);
      if (ser_of(id) === 1'b0) begin
        ep = epoch;
        mis = -1;
        aborted = 1'b0;
        dec = 8'h00;
        e = 8'h00;
        if (id == 0) st_q0.push_back(cyc);
        else st_q1.push_back(cyc);
        have = (id == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
        if (have) begin
          if (id == 0) e = exp_q0.pop_front();
          else e = exp_q1.pop_front();
        end else begin
          total++;
          bad++;
          $display("FAIL unexpected_frame inst=%0d: got a start bit at cycle %0d, required an idle line", id, cyc);
        end
        fr = {1'b1, e, 1'b0};
        for (int k = 0; k < 10 * bt; k++) begin
          if (k > 0) @(negedge clk);
          if (epoch != ep) begin
            aborted = 1'b1;
            break;
          end
          if ((k % bt) == bt / 2 && k / bt >= 1 && k / bt <= 8) dec[k / bt - 1] = ser_of(id);
          if (ser_of(id) !== fr[k / bt] && mis < 0) mis = k;
        end
        if (have && !aborted) begin
          total++;
          if (mis >= 0) begin
            bad++;
            $display("FAIL frame inst=%0d: got byte 0x%02h (first wrong cycle %0d of frame), required 0x%02h",
                     id, dec, mis, e);
          end else if (id == 0) begin
            frames_ok0++;
          end else begin
            frames_ok1++;
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, s, f, g, ok_before, x;
    int a[8];
    logic flag;
    logic [7:0] b;

    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_serial_a", int'(ser_a), 1);
    check("rst_ready_a", int'(ifa.data_in_ready), 1);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_serial_b", int'(ser_b), 1);
    check("rst_ready_b", int'(ifb.data_in_ready), 1);
    check("rst_busy_b", int'(busy_b), 0);

    flag = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (ser_a !== 1'b1) flag = 1'b0;
    end
    check("idle_high_1000", int'(flag), 1);

    // Single byte: start bit appears one edge after acceptance, and busy lasts one whole frame.
    send(0, 8'hA5, a0);
    idle_in(0);
    check("latency_still_high", int'(ser_a), 1);
    check("busy_after_push", int'(busy_a), 1);
    @(negedge clk);
    check("start_bit_edge_n1", int'(ser_a), 0);
    s = cyc;
    wait_idle(0, 6000, f);
    check("busy_len_a5", f - s, 10 * BT_A);

    // Back-to-back stream 0x01..0x06
    st_q0.delete();
    for (int i = 0; i < 5; i++) send(0, 8'(i + 1), a[i]);
    check("ready_low_after_5", int'(ifa.data_in_ready), 0);
    send(0, 8'h06, a[5]);
    idle_in(0);
    flag = 1'b1;
    for (int i = 1; i < 5; i++) if (a[i] != a[0] + i) flag = 1'b0;
    check("burst_consecutive", int'(flag), 1);
    wait_idle(0, 30000, f);
    check("burst_frames", st_q0.size(), 6);
    if (st_q0.size() == 6) begin
      check("burst_first_start", st_q0[0], a[0] + 1);
      check("sixth_after_pop", a[5], st_q0[1] + 1);
      flag = 1'b1;
      for (int i = 1; i < 6; i++) if (st_q0[i] - st_q0[i-1] != 10 * BT_A) flag = 1'b0;
      check("burst_no_gap", int'(flag), 1);
    end

    // Mid-frame reset during data bit 3 of 0xFF, two bytes still queued
    st_q0.delete();
    send(0, 8'hFF, x);
    send(0, 8'h11, x);
    send(0, 8'h22, x);
    idle_in(0);
    g = 0;
    while (st_q0.size() == 0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("rst_frame_started", st_q0.size(), 1);
    s = (st_q0.size() != 0) ? st_q0[0] : cyc;
    while (cyc < s + 4 * BT_A + BT_A / 2) @(negedge clk);
    rst = 1'b1;
    epoch++;
    exp_q0.delete();
    drive(0, 1'b1, 8'h77);
    @(negedge clk);
    rst = 1'b0;
    idle_in(0);
    check("midrst_serial", int'(ser_a), 1);
    check("midrst_ready", int'(ifa.data_in_ready), 1);
    check("midrst_busy", int'(busy_a), 0);
    flag = 1'b1;
    repeat (2000) begin
      @(negedge clk);
      if (ser_a !== 1'b1 || busy_a !== 1'b0) flag = 1'b0;
    end
    check("midrst_quiet", int'(flag), 1);
    ok_before = frames_ok0;
    send(0, 8'h3C, x);
    idle_in(0);
    wait_idle(0, 6000, f);
    check("after_rst_3c", frames_ok0 - ok_before, 1);

    // Instance B: byte 0x80 over a 100-cycle frame
    st_q1.delete();
    send(1, 8'h80, a0);
    idle_in(1);
    wait_idle(1, 500, f);
    check("b_frame_count", st_q1.size(), 1);
    if (st_q1.size() == 1) check("b_frame_len", f - st_q1[0], 10 * BT_B);

    // Instance B: full FIFO with simultaneous pop
    st_q1.delete();
    for (int i = 0; i < 5; i++) send(1, 8'($urandom), a[i]);
    check("b_ready_low_full", int'(ifb.data_in_ready), 0);
    for (int i = 5; i < 8; i++) send(1, 8'($urandom), a[i]);
    idle_in(1);
    wait_idle(1, 2000, f);
    check("b_burst_frames", st_q1.size(), 8);
    if (st_q1.size() == 8) begin
      flag = 1'b1;
      for (int i = 1; i < 5; i++) if (a[i] != a[0] + i) flag = 1'b0;
      for (int i = 5; i < 8; i++) if (a[i] != st_q1[i - 4] + 1) flag = 1'b0;
      check("b_accept_edges", int'(flag), 1);
      flag = 1'b1;
      for (int i = 1; i < 8; i++) if (st_q1[i] - st_q1[i-1] != 10 * BT_B) flag = 1'b0;
      check("b_no_gap", int'(flag), 1);
    end

    // Instance B: random bytes with random idle gaps
    ok_before = frames_ok1;
    repeat (40) begin
      b = 8'($urandom);
      send(1, b, x);
      if ($urandom_range(0, 3) == 0) begin
        idle_in(1);
        repeat ($urandom_range(0, 150)) @(negedge clk);
      end
    end
    idle_in(1);
    wait_idle(1, 10000, f);
    check("b_random_frames", frames_ok1 - ok_before, 40);
    check("exp_q0_empty", exp_q0.size(), 0);
    check("exp_q1_empty", exp_q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
